// File: rtl/ms_pkg.sv
// ms_pkg: shared constants, types and helpers for the minesweeper board
// controller and its LFSR.
//   BOARD_DIM / N_CELLS  board geometry (8x8, 64 cells)
//   ms_state_t           FSM state encoding, exported on ms_board_ctrl.state
//   C_REV/C_FLAG/C_BOMB  bit positions inside an ms_cell_t
//   CMD_REVEAL/CMD_FLAG  cmd_op encodings
package ms_pkg;

  localparam int BOARD_DIM = 8;
  localparam int N_CELLS   = BOARD_DIM * BOARD_DIM;

  typedef logic [2:0] ms_state_t;
  localparam ms_state_t IDLE  = 3'd0;
  localparam ms_state_t CLEAR = 3'd1;
  localparam ms_state_t PLACE = 3'd2;
  localparam ms_state_t COUNT = 3'd3;
  localparam ms_state_t PLAY  = 3'd4;
  localparam ms_state_t LOST  = 3'd5;
  localparam ms_state_t WON   = 3'd6;

  // Cell layout: [7]revealed [6]flagged [5]bomb [4]0 [3:0]adjacent bombs
  typedef logic [7:0] ms_cell_t;
  localparam int C_REV  = 7;
  localparam int C_FLAG = 6;
  localparam int C_BOMB = 5;

  localparam logic CMD_REVEAL = 1'b0;
  localparam logic CMD_FLAG   = 1'b1;

  // A game always has at least one bomb and never more than max_b.
  function automatic logic [3:0] clamp_bombs(input logic [3:0] n, input logic [3:0] max_b);
    if (n == 4'd0) return 4'd1;
    if (n > max_b) return max_b;
    return n;
  endfunction

endpackage

// File: rtl/ms_lfsr8.sv
// ms_lfsr8: 8-bit Galois LFSR, polynomial x^8+x^6+x^5+x^4+1 (maximal length).
//   clk, rst   clock, async active-high reset (reset value DEFAULT_SEED)
//   load       load seed (a zero seed is replaced by DEFAULT_SEED)
//   seed       value to load
//   step       advance one state; load wins over step
//   q          current state, never zero
module ms_lfsr8 #(
  parameter logic [7:0] DEFAULT_SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] seed,
  input  logic       step,
  output logic [7:0] q
);

  logic [7:0] q_next;

  // Right-shift form: when the bit shifted out is 1, the feedback mask 8'hB8
  // folds in the x^8, x^6, x^5 and x^4 terms.
  assign q_next = q[0] ? ((q >> 1) ^ 8'hB8) : (q >> 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       q <= DEFAULT_SEED;
    else if (load) q <= (seed == 8'h00) ? DEFAULT_SEED : seed;
    else if (step) q <= q_next;
  end

endmodule

// File: rtl/ms_board_ctrl.sv
// ms_board_ctrl: owner and sequencer of the 8x8 minesweeper board.
// On start it clears the board, drops bombs at LFSR-chosen cells, fills in
// adjacent-bomb counts, then serves reveal/flag commands and reports win/loss.
//   clk, rst              clock, async active-high reset
//   start, seed, num_bombs  restart request; seed/num_bombs sampled with it
//   cmd_valid/cmd_ready   command handshake (ready only while playing)
//   cmd_op, cmd_x, cmd_y  0=reveal 1=flag toggle, target column/row
//   rd_x, rd_y, rd_cell   combinational board read port for the renderer
//   state, game_lost, game_won  game status for top-level logic
//
// state | meaning
// IDLE  | after reset, waiting for start
// CLEAR | zero one cell per cycle, idx 0..63
// PLACE | one LFSR pick per cycle until bombs_eff distinct bombs placed
// COUNT | write neighbour bomb count of cell idx, idx 0..63
// PLAY  | accept one reveal/flag command per cycle
// LOST  | a bomb was revealed; board frozen until start
// WON   | every safe cell revealed; board frozen until start
module ms_board_ctrl
  import ms_pkg::*;
#(
  parameter logic [7:0] DEFAULT_SEED = 8'hA5,
  parameter int         MAX_BOMBS    = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] seed,
  input  logic [3:0] num_bombs,
  input  logic       cmd_valid,
  input  logic       cmd_op,
  input  logic [2:0] cmd_x,
  input  logic [2:0] cmd_y,
  output logic       cmd_ready,
  input  logic [2:0] rd_x,
  input  logic [2:0] rd_y,
  output logic [7:0] rd_cell,
  output ms_state_t  state,
  output logic       game_lost,
  output logic       game_won
);

  ms_state_t  state_q;
  logic [5:0] idx;
  logic [3:0] placed;
  logic [3:0] bombs_eff;
  logic [6:0] revealed_cnt;
  ms_cell_t   board [N_CELLS];

  logic [7:0] lfsr_q;
  logic [1:0] lfsr_hi_unused;
  logic [5:0] pick;
  logic [5:0] cmd_idx;
  logic [6:0] win_target;
  logic [3:0] nbr_cnt;

  ms_lfsr8 #(.DEFAULT_SEED(DEFAULT_SEED)) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load (start),
    .seed (seed),
    .step ((state_q == PLACE) && !start),
    .q    (lfsr_q)
  );

  // The pick is the LFSR value present during the PLACE cycle, so the first
  // candidate cell is the (substituted) seed itself. Only the low six bits
  // address the board.
  assign pick           = lfsr_q[5:0];
  assign lfsr_hi_unused = lfsr_q[7:6];

  assign cmd_idx    = {cmd_y, cmd_x};
  assign win_target = 7'(N_CELLS) - {3'b000, bombs_eff};

  // Bomb neighbours of cell idx; out-of-board neighbours are skipped, no wrap.
  always_comb begin
    int nr;
    int nc;
    nbr_cnt = 4'd0;
    nr = 0;
    nc = 0;
    for (int dy = -1; dy <= 1; dy++) begin
      for (int dx = -1; dx <= 1; dx++) begin
        nr = int'(idx[5:3]) + dy;
        nc = int'(idx[2:0]) + dx;
        if ((dy != 0 || dx != 0) && nr >= 0 && nr < BOARD_DIM && nc >= 0 && nc < BOARD_DIM) begin
          if (board[6'(nr * BOARD_DIM + nc)][C_BOMB]) nbr_cnt = nbr_cnt + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      idx          <= 6'd0;
      placed       <= 4'd0;
      bombs_eff    <= 4'd0;
      revealed_cnt <= 7'd0;
      for (int i = 0; i < N_CELLS; i++) board[i] <= '0;
    end else if (start) begin
      state_q      <= CLEAR;
      idx          <= 6'd0;
      placed       <= 4'd0;
      revealed_cnt <= 7'd0;
      bombs_eff    <= clamp_bombs(num_bombs, 4'(MAX_BOMBS));
    end else begin
      case (state_q)
        CLEAR: begin
          board[idx] <= '0;
          idx        <= idx + 6'd1;
          if (idx == 6'(N_CELLS - 1)) state_q <= PLACE;
        end
        PLACE: begin
          // A repeat pick just burns the cycle.
          if (!board[pick][C_BOMB]) begin
            board[pick][C_BOMB] <= 1'b1;
            placed              <= placed + 4'd1;
            if (placed + 4'd1 == bombs_eff) state_q <= COUNT;
          end
        end
        COUNT: begin
          board[idx][3:0] <= nbr_cnt;
          idx             <= idx + 6'd1;
          if (idx == 6'(N_CELLS - 1)) state_q <= PLAY;
        end
        PLAY: begin
          if (cmd_valid) begin
            if (cmd_op == CMD_FLAG) begin
              if (!board[cmd_idx][C_REV]) board[cmd_idx][C_FLAG] <= !board[cmd_idx][C_FLAG];
            end else if (!board[cmd_idx][C_REV] && !board[cmd_idx][C_FLAG]) begin
              board[cmd_idx][C_REV] <= 1'b1;
              revealed_cnt          <= revealed_cnt + 7'd1;
              if (board[cmd_idx][C_BOMB])                    state_q <= LOST;
              else if (revealed_cnt + 7'd1 == win_target)    state_q <= WON;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign rd_cell   = board[{rd_y, rd_x}];
  assign state     = state_q;
  assign cmd_ready = (state_q == PLAY);
  assign game_lost = (state_q == LOST);
  assign game_won  = (state_q == WON);

endmodule
